// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: data width, op encodings
// (also imported by CPU decode) and the sequencer state encoding.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_arith(input logic [2:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/muldiv_neg64.sv
// Combinational 64-bit two's-complement negate, shared by operand magnitude
// extraction and result sign fixup.
module neg64 (
  input  logic [63:0] a,
  output logic [63:0] y
);

  assign y = ~a + 64'd1;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, one step per cycle, with sign fixup on the final step.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [1:0]      dbg_state
);

  localparam logic [5:0] LAST_STEP = 6'd32;

  state_t            state;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [5:0]        cnt;
  logic [2*XLEN-1:0] acc;

  logic              is_mult, is_signed, a_neg, b_neg, b_zero;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [63:0]       neg_a, neg_b, neg_res, neg_rem, res_in;
  logic [XLEN:0]     mul_sum, div_diff;
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN-1:0]   res_hi, res_lo;
  logic              unused_bits;

  assign dbg_state = state;
  assign is_mult   = ~op_q[1];
  assign is_signed = ~op_q[0];
  assign a_neg     = is_signed & a_q[XLEN-1];
  assign b_neg     = is_signed & b_q[XLEN-1];
  assign b_zero    = (b_q == '0);

  neg64 u_neg_a (.a({{XLEN{1'b0}}, a_q}), .y(neg_a));
  neg64 u_neg_b (.a({{XLEN{1'b0}}, b_q}), .y(neg_b));

  assign mag_a = a_neg ? neg_a[XLEN-1:0] : a_q;
  assign mag_b = b_neg ? neg_b[XLEN-1:0] : b_q;

  // Multiply keeps {partial product, multiplier}; divide keeps {remainder, quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
    div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, mag_b};
    if (is_mult)
      acc_step = {mul_sum, acc[XLEN-1:1]};
    else if (!div_diff[XLEN])
      acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_step = {acc[2*XLEN-2:0], 1'b0};
  end

  assign res_in = is_mult ? acc_step : {{XLEN{1'b0}}, acc_step[XLEN-1:0]};
  neg64 u_neg_res (.a(res_in), .y(neg_res));
  neg64 u_neg_rem (.a({{XLEN{1'b0}}, acc_step[2*XLEN-1:XLEN]}), .y(neg_rem));

  always_comb begin
    res_hi = acc_step[2*XLEN-1:XLEN];
    res_lo = acc_step[XLEN-1:0];
    if (is_mult) begin
      if (a_neg ^ b_neg) {res_hi, res_lo} = neg_res;
    end else if (b_zero) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      if (a_neg ^ b_neg) res_lo = neg_res[XLEN-1:0];
      if (a_neg)         res_hi = neg_rem[XLEN-1:0];
    end
  end

  assign unused_bits = ^{neg_a[63:XLEN], neg_b[63:XLEN], neg_rem[63:XLEN]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          // Cycle 0 loads operand magnitudes; counts 1..32 are the iteration steps.
          if (cnt == 6'd0)
            acc <= is_mult ? {{XLEN{1'b0}}, mag_b} : {{XLEN{1'b0}}, mag_a};
          else
            acc <= acc_step;
          cnt <= cnt + 6'd1;
          if (cnt == LAST_STEP) begin
            hi       <= res_hi;
            lo       <= res_lo;
            div_zero <= ~is_mult & b_zero;
            cnt      <= '0;
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          done     <= 1'b0;
          div_zero <= 1'b0;
          if (start) begin
            if (is_arith(op)) begin
              op_q  <= op[1:0];
              a_q   <= rs_val;
              b_q   <= rt_val;
              cnt   <= '0;
              state <= ST_RUN;
              busy  <= 1'b1;
            end else if (op == OP_MTHI) begin
              hi <= rs_val;
            end else if (op == OP_MTLO) begin
              lo <= rs_val;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of arithmetic ops plus hand
// sequences for reset, MTHI/MTLO, ignored starts and reset during RUN.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
  } vec_t;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives start for exactly one rising edge; returns 1ns after that edge.
  task automatic pulse_start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Operands are scrambled right after acceptance; the result must not notice.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    pulse_start(o, a, b);
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  task automatic wait_done(input int k0, output int lat);
    lat = -1;
    for (int k = k0 + 1; k <= k0 + 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    vec_t        vecs[13];
    int          lat;
    logic        saw_done;
    logic [63:0] exp;

    vecs[0]  = '{OP_MULT,  32'd4,        32'd7,        32'h00000000, 32'd28,       1'b0};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{OP_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 1'b0};
    vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{OP_DIV,   32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{OP_MULT,  32'd3,        32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[8]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vecs[10] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[11] = '{OP_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[12] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};

    // Clock/reset
    rst = 1'b1; start = 1'b0; op = OP_MULT; rs_val = '0; rt_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_div_zero", div_zero, 0);
    check("reset_hilo", {hi, lo}, 0);
    check("reset_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors, issued back-to-back so each after the first is accepted in DONE
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
      exp_q.push_back({vecs[i].exp_hi, vecs[i].exp_lo});
      check($sformatf("v%0d_busy_run", i), busy, 1);
      wait_done(0, lat);
      check($sformatf("v%0d_latency", i), lat, 33);
      check($sformatf("v%0d_busy_done", i), busy, 0);
      check($sformatf("v%0d_div_zero", i), div_zero, vecs[i].exp_dz);
      exp = exp_q.pop_front();
      check($sformatf("v%0d_hilo", i), {hi, lo}, exp);
    end

    // Starts during RUN are dropped, including MTLO and a second arithmetic op
    issue(OP_MULT, 32'd2, 32'd3);
    exp_q.push_back(64'd6);
    repeat (5) @(posedge clk);
    pulse_start(OP_MTLO, 32'hAA, 32'd0);
    check("run_mtlo_ignored_lo", lo, 0);
    check("run_still_busy", busy, 1);
    pulse_start(OP_DIV, 32'd100, 32'd0);
    wait_done(7, lat);
    check("run_ignore_latency", lat, 33);
    exp = exp_q.pop_front();
    check("run_ignore_hilo", {hi, lo}, exp);
    check("run_ignore_div_zero", div_zero, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("idle_after_done", dbg_state, ST_IDLE);

    // MTHI/MTLO from IDLE, reserved ops ignored
    pulse_start(OP_MTHI, 32'h55, 32'd0);
    check("mthi_hi", hi, 32'h55);
    check("mthi_lo_kept", lo, 32'd6);
    check("mthi_no_busy_done", {busy, done}, 0);
    pulse_start(OP_MTLO, 32'hAA, 32'd0);
    check("mtlo_lo", lo, 32'hAA);
    check("mtlo_hi_kept", hi, 32'h55);
    check("mtlo_no_busy_done", {busy, done}, 0);
    pulse_start(3'b110, 32'h123, 32'd9);
    pulse_start(3'b111, 32'h456, 32'd9);
    check("reserved_busy", busy, 0);
    check("reserved_state", dbg_state, ST_IDLE);
    repeat (3) @(posedge clk);
    #1;
    check("hilo_hold", {hi, lo}, {32'h55, 32'hAA});

    // Reset in RUN cycle 10 discards the op with no done pulse
    issue(OP_MULT, 32'd4, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_run_busy", busy, 0);
    check("rst_run_hilo", {hi, lo}, 0);
    check("rst_run_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("rst_run_no_done", saw_done, 0);

    // Start accepted at the very first edge with rst low
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b1; op = OP_MULTU; rs_val = 32'd6; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    check("first_edge_accept", busy, 1);
    wait_done(0, lat);
    check("first_edge_latency", lat, 33);
    check("first_edge_hilo", {hi, lo}, 64'd42);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
